// File: rtl/pipeline_stage_decode_pkg.sv
// Shared types and defaults for the decode stage: instruction fields, the
// registered decode result and the per-cycle decode action.
package pipeline_stage_decode_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH     = 32;
  localparam int unsigned DEFAULT_REGISTER_COUNT = 32;
  localparam int unsigned REG_INDEX_WIDTH        = $clog2(DEFAULT_REGISTER_COUNT);

  typedef logic [REG_INDEX_WIDTH-1:0] reg_index_t;

  typedef struct packed {
    reg_index_t                    rs1;
    reg_index_t                    rs2;
    reg_index_t                    rd;
    logic                          readsRs1;
    logic                          readsRs2;
    logic                          writesRd;
    logic                          isLoad;
    logic [DEFAULT_DATA_WIDTH-1:0] immediate;
  } instruction_t;

  typedef struct packed {
    logic                          valid;
    logic [DEFAULT_DATA_WIDTH-1:0] programCounter;
    logic                          epoch;
    instruction_t                  instruction;
    logic [DEFAULT_DATA_WIDTH-1:0] rs1Value;
    logic [DEFAULT_DATA_WIDTH-1:0] rs2Value;
  } pipeline_result_decode_t;

  typedef enum logic [1:0] {
    ACTION_IDLE,
    ACTION_PASS,
    ACTION_STALL,
    ACTION_DROP
  } decode_action_t;

  function automatic logic reads_register(input logic       enable,
                                          input reg_index_t source,
                                          input reg_index_t target);
    return enable && (source == target);
  endfunction

endpackage

// File: rtl/register_file.sv
// Architectural register file: two asynchronous read ports with same-cycle
// write-through, one write port, x0 hardwired to zero.
module register_file #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REGISTER_COUNT = 32,
  localparam int unsigned INDEX_WIDTH   = $clog2(REGISTER_COUNT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   write_enable,
  input  logic [INDEX_WIDTH-1:0] write_index,
  input  logic [DATA_WIDTH-1:0]  write_value,
  input  logic [INDEX_WIDTH-1:0] read_index_a,
  output logic [DATA_WIDTH-1:0]  read_value_a,
  input  logic [INDEX_WIDTH-1:0] read_index_b,
  output logic [DATA_WIDTH-1:0]  read_value_b
);

  logic [DATA_WIDTH-1:0] regs [REGISTER_COUNT];
  logic                  write_live;

  assign write_live = write_enable && (write_index != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (write_live) begin
      regs[write_index] <= write_value;
    end
  end

  // A write landing this edge is forwarded so decode never sees a stale value.
  always_comb begin
    read_value_a = regs[read_index_a];
    if (read_index_a == '0) begin
      read_value_a = '0;
    end else if (write_live && (write_index == read_index_a)) begin
      read_value_a = write_value;
    end
  end

  always_comb begin
    read_value_b = regs[read_index_b];
    if (read_index_b == '0) begin
      read_value_b = '0;
    end else if (write_live && (write_index == read_index_b)) begin
      read_value_b = write_value;
    end
  end

endmodule

// File: rtl/pipeline_stage_decode.sv
// Decode stage: reads operands, drops stale-epoch instructions, stalls on
// load-use hazards and registers the result with one cycle of latency.
module pipeline_stage_decode
  import pipeline_stage_decode_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned REGISTER_COUNT = DEFAULT_REGISTER_COUNT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    fetchValid,
  input  logic [DATA_WIDTH-1:0]   fetchProgramCounter,
  input  logic                    fetchEpoch,
  input  instruction_t            fetchInstruction,
  input  logic                    currentEpoch,
  input  logic                    executeValid,
  input  logic                    executeIsLoad,
  input  reg_index_t              executeRd,
  input  logic                    writebackEnable,
  input  reg_index_t              writebackRegister,
  input  logic [DATA_WIDTH-1:0]   writebackValue,
  output logic                    stallOnDecode,
  output pipeline_result_decode_t decodeResult,
  output logic [31:0]             stallCount,
  output logic [31:0]             flushCount
);

  logic [DATA_WIDTH-1:0]   rs1_value;
  logic [DATA_WIDTH-1:0]   rs2_value;
  logic                    stale;
  logic                    load_in_execute;
  logic                    operand_conflict;
  logic                    hazard;
  decode_action_t          action;
  pipeline_result_decode_t next_result;
  logic [31:0]             stall_count;
  logic [31:0]             flush_count;

  register_file #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REGISTER_COUNT (REGISTER_COUNT)
  ) u_register_file (
    .clk          (clock),
    .rst          (reset),
    .write_enable (writebackEnable),
    .write_index  (writebackRegister),
    .write_value  (writebackValue),
    .read_index_a (fetchInstruction.rs1),
    .read_value_a (rs1_value),
    .read_index_b (fetchInstruction.rs2),
    .read_value_b (rs2_value)
  );

  always_comb begin
    stale            = fetchValid && (fetchEpoch != currentEpoch);
    load_in_execute  = executeValid && executeIsLoad && (executeRd != '0);
    operand_conflict = reads_register(fetchInstruction.readsRs1, fetchInstruction.rs1, executeRd)
                    || reads_register(fetchInstruction.readsRs2, fetchInstruction.rs2, executeRd);
    hazard           = fetchValid && !stale && load_in_execute && operand_conflict;
  end

  // Left ungated by reset so fetch sees the hazard even while decode is held.
  assign stallOnDecode = hazard;

  always_comb begin
    action = ACTION_IDLE;
    if (stale) begin
      action = ACTION_DROP;
    end else if (hazard) begin
      action = ACTION_STALL;
    end else if (fetchValid) begin
      action = ACTION_PASS;
    end
  end

  always_comb begin
    next_result = '0;
    if (action == ACTION_PASS) begin
      next_result.valid          = 1'b1;
      next_result.programCounter = fetchProgramCounter;
      next_result.epoch          = fetchEpoch;
      next_result.instruction    = fetchInstruction;
      next_result.rs1Value       = rs1_value;
      next_result.rs2Value       = rs2_value;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      decodeResult <= '0;
      stall_count  <= '0;
      flush_count  <= '0;
    end else begin
      decodeResult <= next_result;
      if (action == ACTION_STALL) begin
        stall_count <= stall_count + 32'd1;
      end
      if (action == ACTION_DROP) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end

  assign stallCount = stall_count;
  assign flushCount = flush_count;

endmodule

// File: tb/tb_pipeline_stage_decode.sv
// Scoreboard bench for pipeline_stage_decode: expected results are queued as
// stimulus is driven and compared one cycle later.
module tb_pipeline_stage_decode;
  import pipeline_stage_decode_pkg::*;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    fetchValid;
  logic [31:0]             fetchProgramCounter;
  logic                    fetchEpoch;
  instruction_t            fetchInstruction;
  logic                    currentEpoch;
  logic                    executeValid;
  logic                    executeIsLoad;
  reg_index_t              executeRd;
  logic                    writebackEnable;
  reg_index_t              writebackRegister;
  logic [31:0]             writebackValue;
  logic                    stallOnDecode;
  pipeline_result_decode_t decodeResult;
  logic [31:0]             stallCount;
  logic [31:0]             flushCount;

  pipeline_stage_decode #(
    .DATA_WIDTH     (32),
    .REGISTER_COUNT (32)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .fetchValid          (fetchValid),
    .fetchProgramCounter (fetchProgramCounter),
    .fetchEpoch          (fetchEpoch),
    .fetchInstruction    (fetchInstruction),
    .currentEpoch        (currentEpoch),
    .executeValid        (executeValid),
    .executeIsLoad       (executeIsLoad),
    .executeRd           (executeRd),
    .writebackEnable     (writebackEnable),
    .writebackRegister   (writebackRegister),
    .writebackValue      (writebackValue),
    .stallOnDecode       (stallOnDecode),
    .decodeResult        (decodeResult),
    .stallCount          (stallCount),
    .flushCount          (flushCount)
  );

  always #5 clock = ~clock;

  int                      checks = 0;
  int                      errors = 0;
  pipeline_result_decode_t expq[$];
  logic [31:0]             exp_stall;
  logic [31:0]             exp_flush;

  function automatic instruction_t mk(input reg_index_t rs1, input reg_index_t rs2,
                                      input reg_index_t rd, input logic r1, input logic r2,
                                      input logic wr, input logic ld, input logic [31:0] imm);
    instruction_t ins;
    ins.rs1 = rs1; ins.rs2 = rs2; ins.rd = rd;
    ins.readsRs1 = r1; ins.readsRs2 = r2; ins.writesRd = wr; ins.isLoad = ld;
    ins.immediate = imm;
    return ins;
  endfunction

  function automatic pipeline_result_decode_t res(input logic [31:0] pc, input logic ep,
                                                  input instruction_t ins,
                                                  input logic [31:0] v1, input logic [31:0] v2);
    pipeline_result_decode_t r;
    r.valid = 1'b1; r.programCounter = pc; r.epoch = ep; r.instruction = ins;
    r.rs1Value = v1; r.rs2Value = v2;
    return r;
  endfunction

  task automatic idle_inputs();
    fetchValid = 1'b0; fetchProgramCounter = '0; fetchEpoch = currentEpoch;
    fetchInstruction = '0; executeValid = 1'b0; executeIsLoad = 1'b0; executeRd = '0;
    writebackEnable = 1'b0; writebackRegister = '0; writebackValue = '0;
  endtask

  task automatic fetch(input logic [31:0] pc, input instruction_t ins);
    fetchValid = 1'b1; fetchProgramCounter = pc; fetchEpoch = currentEpoch; fetchInstruction = ins;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    pipeline_result_decode_t got;
    reset = 1'b1; currentEpoch = 1'b0;
    idle_inputs();
    repeat (2) tick();
    got = decodeResult;
    checks++; if (got !== '0) begin errors++; $display("FAIL reset_result: got %h expected 0", got); end
    checks++; if (stallCount !== 32'd0) begin errors++; $display("FAIL reset_stall: got %h expected 0", stallCount); end
    checks++; if (flushCount !== 32'd0) begin errors++; $display("FAIL reset_flush: got %h expected 0", flushCount); end
    fetch(32'h40, mk(5'd3, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0));
    executeValid = 1'b1; executeIsLoad = 1'b1; executeRd = 5'd3;
    #1;
    checks++; if (stallOnDecode !== 1'b1) begin errors++; $display("FAIL reset_stall_ungated: got %b expected 1", stallOnDecode); end
    idle_inputs();
    reset = 1'b0;
    exp_stall = '0; exp_flush = '0;
    expq.push_back('0);
    tick();
    got = decodeResult;
    checks++; if (got !== expq.pop_front()) begin errors++; $display("FAIL post_reset_idle: got %h expected 0", got); end
  endtask

  task automatic test_write_read();
    pipeline_result_decode_t got, e;
    instruction_t ins;
    idle_inputs();
    writebackEnable = 1'b1; writebackRegister = 5'd5; writebackValue = 32'h1234;
    expq.push_back('0);
    tick();
    got = decodeResult; e = expq.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL wb_cycle: got %h expected %h", got, e); end
    idle_inputs();
    ins = mk(5'd5, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h10);
    fetch(32'h100, ins);
    expq.push_back(res(32'h100, 1'b0, ins, 32'h1234, 32'h0));
    #1;
    checks++; if (decodeResult.valid !== 1'b0) begin errors++; $display("FAIL latency_pre_edge: got %b expected 0", decodeResult.valid); end
    tick();
    got = decodeResult; e = expq.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL read_x5: got %h expected %h", got, e); end
    checks++; if (got.rs1Value !== 32'h1234) begin errors++; $display("FAIL read_x5_value: got %h expected 1234", got.rs1Value); end
  endtask

  task automatic test_load_use();
    pipeline_result_decode_t got, e;
    instruction_t ins;
    idle_inputs();
    ins = mk(5'd1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 32'h20);
    fetch(32'h104, ins);
    executeValid = 1'b1; executeIsLoad = 1'b1; executeRd = 5'd3;
    writebackEnable = 1'b1; writebackRegister = 5'd3; writebackValue = 32'hABCD;
    #1;
    checks++; if (stallOnDecode !== 1'b1) begin errors++; $display("FAIL load_use_stall: got %b expected 1", stallOnDecode); end
    expq.push_back('0); exp_stall = exp_stall + 32'd1;
    tick();
    got = decodeResult; e = expq.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL stall_bubble: got %h expected %h", got, e); end
    checks++; if (stallCount !== exp_stall) begin errors++; $display("FAIL stall_count: got %h expected %h", stallCount, exp_stall); end
    executeValid = 1'b0; writebackEnable = 1'b0;
    #1;
    checks++; if (stallOnDecode !== 1'b0) begin errors++; $display("FAIL stall_cleared: got %b expected 0", stallOnDecode); end
    expq.push_back(res(32'h104, 1'b0, ins, 32'h0, 32'hABCD));
    tick();
    got = decodeResult; e = expq.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL after_stall: got %h expected %h", got, e); end
    checks++; if (stallCount !== exp_stall) begin errors++; $display("FAIL stall_count_held: got %h expected %h", stallCount, exp_stall); end
  endtask

  task automatic test_stale();
    pipeline_result_decode_t got, e;
    instruction_t ins;
    idle_inputs();
    currentEpoch = 1'b1;
    ins = mk(5'd1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 32'h20);
    fetch(32'h108, ins);
    fetchEpoch = 1'b0;
    executeValid = 1'b1; executeIsLoad = 1'b1; executeRd = 5'd3;
    writebackEnable = 1'b1; writebackRegister = 5'd9; writebackValue = 32'h55;
    #1;
    checks++; if (stallOnDecode !== 1'b0) begin errors++; $display("FAIL stale_no_stall: got %b expected 0", stallOnDecode); end
    expq.push_back('0); exp_flush = exp_flush + 32'd1;
    tick();
    got = decodeResult; e = expq.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL stale_drop: got %h expected %h", got, e); end
    checks++; if (flushCount !== exp_flush) begin errors++; $display("FAIL flush_count: got %h expected %h", flushCount, exp_flush); end
    checks++; if (stallCount !== exp_stall) begin errors++; $display("FAIL stale_stall_count: got %h expected %h", stallCount, exp_stall); end
    idle_inputs();
    ins = mk(5'd9, 5'd3, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    fetch(32'h10C, ins);
    expq.push_back(res(32'h10C, 1'b1, ins, 32'h55, 32'hABCD));
    tick();
    got = decodeResult; e = expq.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL read_after_drop: got %h expected %h", got, e); end
  endtask

  task automatic test_bypass();
    pipeline_result_decode_t got, e;
    instruction_t ins;
    idle_inputs();
    ins = mk(5'd7, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    fetch(32'h110, ins);
    writebackEnable = 1'b1; writebackRegister = 5'd7; writebackValue = 32'hDEAD;
    expq.push_back(res(32'h110, 1'b1, ins, 32'hDEAD, 32'h0));
    tick();
    got = decodeResult; e = expq.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL write_through: got %h expected %h", got, e); end
    ins = mk(5'd0, 5'd7, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    fetch(32'h114, ins);
    writebackRegister = 5'd0; writebackValue = 32'hFFFF;
    expq.push_back(res(32'h114, 1'b1, ins, 32'h0, 32'hDEAD));
    tick();
    got = decodeResult; e = expq.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL x0_write_through: got %h expected %h", got, e); end
    writebackEnable = 1'b0;
    ins = mk(5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    fetch(32'h118, ins);
    expq.push_back(res(32'h118, 1'b1, ins, 32'h0, 32'h0));
    tick();
    got = decodeResult; e = expq.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL x0_read: got %h expected %h", got, e); end
  endtask

  task automatic test_back_to_back();
    pipeline_result_decode_t got, e;
    instruction_t ins;
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      case (i)
        0: begin
          ins = mk(5'd5, 5'd9, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1);
          fetch(32'h200, ins);
          executeValid = 1'b1; executeIsLoad = 1'b0; executeRd = 5'd5;
          expq.push_back(res(32'h200, 1'b1, ins, 32'h1234, 32'h55));
        end
        1: expq.push_back('0);
        2: begin
          ins = mk(5'd0, 5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 32'h2);
          fetch(32'h208, ins);
          executeValid = 1'b1; executeIsLoad = 1'b1; executeRd = 5'd0;
          expq.push_back(res(32'h208, 1'b1, ins, 32'h0, 32'hDEAD));
        end
        3: begin
          ins = mk(5'd7, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 32'h3);
          fetch(32'h20C, ins);
          executeValid = 1'b1; executeIsLoad = 1'b1; executeRd = 5'd3;
          expq.push_back(res(32'h20C, 1'b1, ins, 32'hDEAD, 32'hABCD));
        end
        default: begin
          ins = mk(5'd9, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4);
          fetch(32'h210, ins);
          executeValid = 1'b0; executeIsLoad = 1'b1; executeRd = 5'd9;
          expq.push_back(res(32'h210, 1'b1, ins, 32'h55, 32'h0));
        end
      endcase
      #1;
      checks++; if (stallOnDecode !== 1'b0) begin errors++; $display("FAIL b2b_no_stall[%0d]: got %b expected 0", i, stallOnDecode); end
      tick();
      got = decodeResult; e = expq.pop_front();
      checks++; if (got !== e) begin errors++; $display("FAIL b2b[%0d]: got %h expected %h", i, got, e); end
    end
    checks++; if (stallCount !== exp_stall) begin errors++; $display("FAIL b2b_stall_count: got %h expected %h", stallCount, exp_stall); end
  endtask

  task automatic test_counter_wrap();
    pipeline_result_decode_t got, e;
    idle_inputs();
    force dut.stall_count = 32'hFFFF_FFFF;
    #1;
    release dut.stall_count;
    exp_stall = 32'hFFFF_FFFF;
    checks++; if (stallCount !== exp_stall) begin errors++; $display("FAIL preload_stall: got %h expected %h", stallCount, exp_stall); end
    fetch(32'h300, mk(5'd5, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0));
    executeValid = 1'b1; executeIsLoad = 1'b1; executeRd = 5'd5;
    expq.push_back('0); exp_stall = exp_stall + 32'd1;
    tick();
    got = decodeResult; e = expq.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL wrap_bubble: got %h expected %h", got, e); end
    checks++; if (stallCount !== exp_stall) begin errors++; $display("FAIL stall_wrap: got %h expected %h", stallCount, exp_stall); end
  endtask

  task automatic test_reset_mid_stall();
    pipeline_result_decode_t got, e;
    instruction_t ins;
    idle_inputs();
    ins = mk(5'd5, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8);
    fetch(32'h400, ins);
    expq.push_back(res(32'h400, 1'b1, ins, 32'h1234, 32'h0));
    tick();
    got = decodeResult; e = expq.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL pre_reset_valid: got %h expected %h", got, e); end
    executeValid = 1'b1; executeIsLoad = 1'b1; executeRd = 5'd5;
    #2;
    reset = 1'b1;
    #1;
    got = decodeResult;
    checks++; if (got !== '0) begin errors++; $display("FAIL async_reset_result: got %h expected 0", got); end
    checks++; if (stallCount !== 32'd0) begin errors++; $display("FAIL async_reset_stall: got %h expected 0", stallCount); end
    checks++; if (flushCount !== 32'd0) begin errors++; $display("FAIL async_reset_flush: got %h expected 0", flushCount); end
    checks++; if (stallOnDecode !== 1'b1) begin errors++; $display("FAIL reset_stall_visible: got %b expected 1", stallOnDecode); end
    expq.delete();
    tick();
    idle_inputs();
    reset = 1'b0;
    ins = mk(5'd5, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8);
    fetch(32'h404, ins);
    expq.push_back(res(32'h404, 1'b1, ins, 32'h0, 32'h0));
    tick();
    got = decodeResult; e = expq.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL x5_after_reset: got %h expected %h", got, e); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_load_use();
    test_stale();
    test_bypass();
    test_back_to_back();
    test_counter_wrap();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_decode.md
PIPELINE_STAGE_DECODE -- requirements
Module: pipeline_stage_decode

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of register values and program counter.
REQ-002 Parameter REGISTER_COUNT, default 32: architectural registers; index width is log2(REGISTER_COUNT).
REQ-003 clock  in  1  sole clock; all state updates on posedge clock.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 fetchValid  in  1  fetch result register holds a real instruction.
REQ-006 fetchProgramCounter  in  DATA_WIDTH  PC of the fetched instruction.
REQ-007 fetchEpoch  in  1  PC changed-times bit captured at fetch.
REQ-008 fetchInstruction  in  instruction_t  decoded fields: rs1, rs2, rd, readsRs1, readsRs2, writesRd, isLoad, immediate.
REQ-009 currentEpoch  in  1  live PC changed-times bit; toggles on every taken jump.
REQ-010 executeValid, executeIsLoad  in  1 each; executeRd  in  index width: instruction now in execute.
REQ-011 writebackEnable  in  1; writebackRegister  in  index width; writebackValue  in  DATA_WIDTH.
REQ-012 stallOnDecode  out  1  combinational; tells fetch to hold its result register and PC.
REQ-013 decodeResult  out  pipeline_result_decode_t  registered: valid, programCounter, epoch, instruction, rs1Value, rs2Value.
REQ-014 stallCount, flushCount  out  32 each  registered event counters.

Function
REQ-015 Latency SHALL be one cycle: inputs sampled at edge N appear on decodeResult after edge N.
REQ-016 Stale: fetchValid=1 and fetchEpoch!=currentEpoch; stale instruction SHALL be dropped (decodeResult.valid=0 next cycle), flushCount incremented.
REQ-017 Hazard: fetchValid, not stale, executeValid, executeIsLoad, executeRd!=0, and (readsRs1 and rs1==executeRd, or readsRs2 and rs2==executeRd).
REQ-018 stallOnDecode SHALL equal hazard; a stale instruction SHALL never raise stallOnDecode (stale wins).
REQ-019 On hazard decode SHALL emit a bubble (valid=0), increment stallCount, and re-evaluate the held input next cycle.
REQ-020 Otherwise decodeResult.valid SHALL equal fetchValid and other fields SHALL carry the input with read operands.
REQ-021 Operand reads of register 0 SHALL return 0 regardless of writes.
REQ-022 Write-through: writebackEnable with writebackRegister==rsX (nonzero) in the same cycle SHALL return writebackValue.
REQ-023 Register write SHALL occur at the edge when writebackEnable=1 and writebackRegister!=0; writes to 0 ignored.
REQ-024 Writeback SHALL proceed during stall and stale-drop cycles.
REQ-025 Counters SHALL wrap modulo 2^32; they never saturate.
REQ-026 When decodeResult.valid=0 the non-valid fields SHALL be zero.

Reset
REQ-027 While reset=1: decodeResult all zero, stallCount=0, flushCount=0, all registers 0.
REQ-028 stallOnDecode is combinational; reset SHALL NOT gate it.
REQ-029 Reset asserted mid-stall SHALL discard the pending instruction; first edge after release samples inputs normally.

Structure
REQ-030 instruction_t, pipeline_result_decode_t, reg_index_t, DATA_WIDTH and REGISTER_COUNT defaults SHALL live in the shared definitions package.
REQ-031 Register storage with bypass SHALL be one sub-module, register_file (two async read ports, one write port, async reset).
REQ-032 Hazard and stale detection SHALL stay combinational inside pipeline_stage_decode.

Verification
REQ-033 Reset then write x5=0x1234 via writeback; decode reads rs1=5 next cycle -> rs1Value=0x1234, valid=1, latency 1.
REQ-034 Execute holds load to rd=3, fetch instruction reads rs2=3 -> stallOnDecode=1 that cycle, bubble out, stallCount=1; next cycle load gone -> valid=1.
REQ-035 fetchEpoch=0, currentEpoch=1 with same load-use pattern -> stallOnDecode=0, valid=0, flushCount=1, stallCount unchanged.
REQ-036 writeback x7=0xDEAD same cycle as read of rs1=7 -> rs1Value=0xDEAD; writeback x0=0xFFFF then read rs1=0 -> 0.
REQ-037 Preload stallCount to 0xFFFFFFFF via forced hazards, one more hazard -> stallCount=0.
REQ-038 Assert reset asynchronously mid-stall -> decodeResult and counters zero before next edge; after release x5 reads 0.
